// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the LEGv8 hazard/forwarding controller.
package cpu_pkg;
  localparam logic [4:0] XZR_IDX = 5'd31;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       flag_en;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       rn_used;
    logic       rm_used;
  } stage_desc_t;
endpackage

// File: rtl/operand_fwd_sel.sv
// operand_fwd_sel: per-operand writer comparator; hit = {MEM, EX} match of the ID source, fwd = EX operand source.
module operand_fwd_sel
  import cpu_pkg::*;
(
  input  logic [2:0]      wr,
  input  logic [2:0][4:0] rd,
  input  logic [4:0]      id_src,
  input  logic            id_used,
  input  logic [4:0]      ex_src,
  input  logic            ex_used,
  output logic [1:0]      hit,
  output fwd_sel_t        fwd
);
  assign hit = {id_used && wr[1] && rd[1] == id_src, id_used && wr[0] && rd[0] == id_src};
  assign fwd = (ex_used && wr[1] && rd[1] == ex_src) ? FWD_MEM :
               (ex_used && wr[2] && rd[2] == ex_src) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: LEGv8 stall/bubble/flush/forward control; PIPE_FORWARDING_EN enables EX forwarding.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int         CNT_W = 32,
  parameter logic [4:0] XZR   = XZR_IDX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_flag_en,
  input  logic             id_is_blt,
  input  logic             ex_br_taken,
  input  logic             pipe_freeze,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);
  stage_desc_t ex, mem, wb, id_desc;
  logic [2:0] wr;
  logic [2:0][4:0] rd;
  logic [1:0] hit_a, hit_b;
  fwd_sel_t sel_a, sel_b;
  logic load_use, flag_haz, haz;
  assign wr = {wb.valid && wb.reg_write && wb.rd != XZR,
               mem.valid && mem.reg_write && mem.rd != XZR,
               ex.valid && ex.reg_write && ex.rd != XZR};
  assign rd = {wb.rd, mem.rd, ex.rd};
  operand_fwd_sel u_fwd_a (
    .wr(wr), .rd(rd), .id_src(id_rn), .id_used(id_valid && id_rn_used),
    .ex_src(ex.rn), .ex_used(ex.valid && ex.rn_used), .hit(hit_a), .fwd(sel_a)
  );
  operand_fwd_sel u_fwd_b (
    .wr(wr), .rd(rd), .id_src(id_rm), .id_used(id_valid && id_rm_used),
    .ex_src(ex.rm), .ex_used(ex.valid && ex.rm_used), .hit(hit_b), .fwd(sel_b)
  );
  assign load_use = ex.mem_read && (hit_a[0] || hit_b[0]);
  assign flag_haz = id_valid && id_is_blt && ex.valid && ex.flag_en;
`ifdef PIPE_FORWARDING_EN
  logic unused_bits;
  assign unused_bits = ^{mem, wb};
  assign haz   = load_use || flag_haz;
  assign fwd_a = sel_a;
  assign fwd_b = sel_b;
`else
  logic unused_bits;
  assign unused_bits = ^{mem, wb, sel_a, sel_b, load_use};
  assign haz   = (|hit_a) || (|hit_b) || flag_haz;
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif
  // freeze dominates everything; a taken branch discards the stalled wrong-path instruction
  assign pc_stall    = pipe_freeze || (!ex_br_taken && haz);
  assign ifid_stall  = pc_stall;
  assign idex_bubble = !pipe_freeze && (ex_br_taken || haz);
  assign ifid_flush  = !pipe_freeze && ex_br_taken;
  assign id_desc = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read,
                     flag_en: id_flag_en, rn: id_rn, rm: id_rm, rn_used: id_rn_used,
                     rm_used: id_rm_used};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      stall_cycles <= '0;
    end else if (!pipe_freeze) begin
      wb <= mem;
      mem <= ex;
      ex <= (id_valid && !idex_bubble) ? id_desc : '0;
      if (pc_stall) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and forwarding controller for the 5-stage LEGv8 pipeline. Sits beside the ID stage and tracks every issued instruction's destination, register-write, load and flag-set attributes through EX, MEM and WB in an internal descriptor pipeline. From that state it generates:
- PC and IF/ID stall.
- ID/EX bubble insertion.
- Branch flush.
- EX-stage operand forwarding selects.
- A stall-cycle performance counter.

## Interface
Parameters:
- CNT_W, 32, width of stall-cycle counter.
- XZR, 5'd31, zero register index; never creates a hazard.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rn, id_rm  in  5 each  source register indices decoded in ID.
- id_rn_used, id_rm_used  in  1 each  ID instruction reads that operand (Rn_True/Rm_True).
- id_rd  in  5  destination index of ID instruction.
- id_reg_write, id_mem_read, id_flag_en  in  1 each  decoded control of ID instruction.
- id_is_blt  in  1  ID instruction is B.LT (consumes flags).
- ex_br_taken  in  1  branch in EX resolved taken.
- pipe_freeze  in  1  memory-wait; whole pipeline holds.
- pc_stall, ifid_stall  out  1 each  hold PC and IF/ID.
- idex_bubble  out  1  load NOP into ID/EX.
- ifid_flush  out  1  squash IF/ID contents.
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1 due to hazards.

## Operation
- Descriptor pipeline: three registered slots (EX, MEM, WB). Each slot holds valid, rd, reg_write, mem_read, flag_en, rn, rm, rn_used, rm_used.
- On each non-frozen cycle:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields if id_valid and no stall/flush; otherwise EX<=bubble (valid=0).
- Writer match: slot.valid && slot.reg_write && slot.rd!=XZR && slot.rd==src && src_used.
- Load-use hazard: ID source matches EX slot with mem_read=1. Result: pc_stall=ifid_stall=idex_bubble=1 for one cycle.
- Flag hazard: id_is_blt && EX slot valid && flag_en. Result: same one-cycle stall (flags written at end of EX).
- Branch: ex_br_taken -> ifid_flush=1 and idex_bubble=1. Stall outputs forced 0 (wrong-path instruction discarded).
- Forwarding: computed from EX slot operands vs MEM/WB slots. MEM match has priority over WB match. Source XZR or unused gives 00.
- pipe_freeze=1:
  - All descriptors hold and counter holds.
  - pc_stall=ifid_stall=1; idex_bubble=0; ifid_flush=0.
  - A taken branch stays pending in EX and flushes on the first unfrozen cycle.
- stall_cycles increments when pc_stall=1 and pipe_freeze=0. Wraps modulo 2^CNT_W.

## Timing
- Stall, bubble and flush outputs are combinational from ID inputs plus registered slots. They are valid in the same cycle the hazard appears in ID.
- fwd_a/fwd_b depend only on registered slots; valid from cycle start.
- Load-use stall: exactly 1 cycle. The consuming instruction issues next cycle with a 01 forward.
- Branch flush penalty: 2 cycles (IF/ID and ID/EX squashed).
- Priority: pipe_freeze > ex_br_taken > load-use/flag stall.
- Reset (reset_n=0 at edge): all slots invalid, stall_cycles=0. All outputs evaluate to 0 on the following cycle. Reset mid-stall discards the stall.

## Configuration
- PIPE_FORWARDING_EN defined:
  - Forwarding as above.
  - Only load-use and flag hazards stall.
- Undefined:
  - fwd_a=fwd_b=00 always.
  - Any ID source matching a writer in EX or MEM slot stalls. The WB slot is excluded because the register file is write-before-read.
  - Worst case is 2 stall cycles.

## Structure
- cpu_pkg holds:
  - fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB).
  - stage_desc_t packed struct.
  - Constant XZR_IDX.
- One sub-module, operand_fwd_sel: combinational per-operand comparator producing a match vector and fwd select. Instantiated twice, for operands A and B.

## Test plan
- EX: ADD X1 writes; ID: SUB reads X1 -> no stall; next cycle fwd_a=10. With macro undefined -> 2 stall cycles, stall_cycles=2.
- EX: LDUR X2; ID: ADD X3,X2,X4 -> pc_stall=idex_bubble=1 for 1 cycle, then fwd_a=01.
- EX: SUBS (flag_en=1); ID: B.LT -> 1-cycle stall; no stall if EX is ADD.
- ex_br_taken=1 while load-use hazard is present -> ifid_flush=1, pc_stall=0, EX slot bubble.
- EX writes X31, ID reads X31 -> no stall, fwd=00.
- pipe_freeze=1 for 3 cycles during a pending taken branch -> slots and counter unchanged; flush fires on cycle 4. Reset asserted mid-stall -> all outputs 0 next cycle.
